// File: rtl/serial_div_pkg.sv
// Shared constants and state encoding for the EX-stage multi-cycle divider.
package serial_div_pkg;

    localparam logic DIV_START         = 1'b1;
    localparam logic DIV_STOP          = 1'b0;
    localparam logic DIV_RES_READY     = 1'b1;
    localparam logic DIV_RES_NOT_READY = 1'b0;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/serial_div.sv
// Restoring divider answering the EX divide handshake; one quotient bit per cycle,
// result is {remainder, quotient} with signed fixups applied on the final step.
module serial_div
    import serial_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int              CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e            r_state;
    div_state_e            w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_dividend;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_signed;
    logic                  r_neg1;
    logic                  r_neg2;

    logic                  w_accept;
    logic                  w_by_zero;
    logic                  w_last;
    logic [DATA_W-1:0]     w_mag1;
    logic [DATA_W-1:0]     w_mag2;
    logic [DATA_W:0]       w_diff;
    logic [2*DATA_W:0]     w_step;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    assign w_accept  = (start_i == DIV_START) && !annul_i;
    assign w_by_zero = (opdata2_i == '0);
    assign w_last    = (r_cnt == LAST_STEP);

    assign w_mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Only bits [63:0] of the 65-bit working value feed the next step; bit 64
    // matters solely for the remainder taken from the final step result.
    assign w_diff = {1'b0, r_dividend[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
    assign w_step = w_diff[DATA_W] ? {r_dividend, 1'b0}
                                   : {w_diff[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};

    assign w_quot = (r_signed && (r_neg1 ^ r_neg2)) ? -w_step[DATA_W-1:0]
                                                    :  w_step[DATA_W-1:0];
    assign w_rem  = (r_signed && r_neg1) ? -w_step[2*DATA_W:DATA_W+1]
                                         :  w_step[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DivFree;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DivFree: begin
                if (w_accept) begin
                    w_state_next = w_by_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: w_state_next = DivEnd;
            DivOn: begin
                if (annul_i) begin
                    w_state_next = DivFree;
                end else if (w_last) begin
                    w_state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DIV_STOP) begin
                    w_state_next = DivFree;
                end
            end
            default: w_state_next = DivFree;
        endcase
    end

    // Datapath and registered outputs follow the same state decode as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_neg1     <= 1'b0;
            r_neg2     <= 1'b0;
            result_o   <= '0;
            ready_o    <= DIV_RES_NOT_READY;
        end else begin
            case (r_state)
                DivFree: begin
                    result_o <= '0;
                    ready_o  <= DIV_RES_NOT_READY;
                    if (w_accept && !w_by_zero) begin
                        r_cnt      <= '0;
                        r_signed   <= signed_div_i;
                        r_neg1     <= opdata1_i[DATA_W-1];
                        r_neg2     <= opdata2_i[DATA_W-1];
                        r_divisor  <= w_mag2;
                        r_dividend <= {{(DATA_W-1){1'b0}}, w_mag1, 1'b0};
                    end
                end
                DivByZero: begin
                    result_o <= '0;
                    ready_o  <= DIV_RES_READY;
                end
                DivOn: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= DIV_RES_NOT_READY;
                    end else begin
                        r_dividend <= w_step[2*DATA_W-1:0];
                        r_cnt      <= r_cnt + 1'b1;
                        if (w_last) begin
                            result_o <= {w_rem, w_quot};
                            ready_o  <= DIV_RES_READY;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DIV_STOP) begin
                        result_o <= '0;
                        ready_o  <= DIV_RES_NOT_READY;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= DIV_RES_NOT_READY;
                end
            endcase
        end
    end

endmodule
